// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALU control codes and stage state encoding for the ALU operand stage.
// The forwarding match helper is used by the operand mux when ALU_STAGE_FWD_EN is defined.
package alu_operand_stage_pkg;

    localparam int WIDTH   = 32;
    localparam int CTRL_W  = 6;
    localparam int RADDR_W = 5;

    localparam logic [CTRL_W-1:0] ALU_NOP = 6'h00;
    localparam logic [CTRL_W-1:0] ALU_ADD = 6'h20;
    localparam logic [CTRL_W-1:0] ALU_SUB = 6'h22;
    localparam logic [CTRL_W-1:0] ALU_AND = 6'h24;
    localparam logic [CTRL_W-1:0] ALU_OR  = 6'h25;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LIVE  = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    function automatic logic fwd_match(input logic                we,
                                       input logic [RADDR_W-1:0] fwd_addr,
                                       input logic [RADDR_W-1:0] src_addr);
        return we && (fwd_addr == src_addr) && (src_addr != '0);
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side signal bundle of the ALU operand stage.
// master = decode/forwarding sources, slave = the operand stage itself.
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [RADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic               use_imm;
    logic [CTRL_W-1:0]  alucont_in;
    logic               stall;
    logic               flush;
    logic               mem_fwd_we;
    logic [RADDR_W-1:0] mem_fwd_addr;
    logic [WIDTH-1:0]   mem_fwd_data;
    logic               wb_fwd_we;
    logic [RADDR_W-1:0] wb_fwd_addr;
    logic [WIDTH-1:0]   wb_fwd_data;
    logic               out_valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [CTRL_W-1:0]  alucont;
    logic [RADDR_W-1:0] dest_addr;

    modport master (
        output in_valid, rs_addr, rt_addr, rd_addr, rs_data, rt_data, imm, use_imm,
               alucont_in, stall, flush, mem_fwd_we, mem_fwd_addr, mem_fwd_data,
               wb_fwd_we, wb_fwd_addr, wb_fwd_data,
        input  in_ready, out_valid, a, b, alucont, dest_addr
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, rd_addr, rs_data, rt_data, imm, use_imm,
               alucont_in, stall, flush, mem_fwd_we, mem_fwd_addr, mem_fwd_data,
               wb_fwd_we, wb_fwd_addr, wb_fwd_data,
        output in_ready, out_valid, a, b, alucont, dest_addr
    );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand forwarding select (combinational); MEM beats WB at capture, WB beats MEM while held.
// With ALU_STAGE_FWD_EN undefined the base data passes straight through.
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] i_src_addr,
    input  logic [WIDTH-1:0]   i_rf_data,
    input  logic               i_wb_first,
    input  logic               i_mem_we,
    input  logic [RADDR_W-1:0] i_mem_addr,
    input  logic [WIDTH-1:0]   i_mem_data,
    input  logic               i_wb_we,
    input  logic [RADDR_W-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]   i_wb_data,
    output logic [WIDTH-1:0]   o_data
);

`ifdef ALU_STAGE_FWD_EN
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = fwd_match(i_mem_we, i_mem_addr, i_src_addr);
    assign w_wb_hit  = fwd_match(i_wb_we, i_wb_addr, i_src_addr);

    // A held entry already absorbed the older MEM value, so the newer WB write takes over.
    always_comb begin
        o_data = i_rf_data;
        if (i_wb_first) begin
            if (w_wb_hit)       o_data = i_wb_data;
            else if (w_mem_hit) o_data = i_mem_data;
        end else begin
            if (w_mem_hit)      o_data = i_mem_data;
            else if (w_wb_hit)  o_data = i_wb_data;
        end
    end
`else
    logic w_fwd_unused;

    assign w_fwd_unused = ^{i_src_addr, i_wb_first, i_mem_we, i_mem_addr, i_mem_data,
                            i_wb_we, i_wb_addr, i_wb_data};
    assign o_data       = i_rf_data;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU: 1-cycle capture latency, MEM/WB forwarding under ALU_STAGE_FWD_EN.
// Backpressure: stall holds the live entry (in_ready low) while it keeps snooping the result buses.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    alu_operand_stage_if.slave stg
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_out_valid;
    logic               w_hold;
    logic               w_accept;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CTRL_W-1:0]  r_alucont;
    logic [RADDR_W-1:0] r_dest;
    logic [RADDR_W-1:0] r_rs_addr;
    logic [RADDR_W-1:0] r_rt_addr;
    logic               r_use_imm;

    logic [RADDR_W-1:0] w_a_src;
    logic [RADDR_W-1:0] w_b_src;
    logic [WIDTH-1:0]   w_a_base;
    logic [WIDTH-1:0]   w_b_base;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_EMPTY;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (stg.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (stg.in_valid) w_state_nxt = ST_LIVE;
                ST_LIVE, ST_HELD: begin
                    if (stg.stall)         w_state_nxt = ST_HELD;
                    else if (stg.in_valid) w_state_nxt = ST_LIVE;
                    else                   w_state_nxt = ST_EMPTY;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = (r_state != ST_EMPTY);
        w_hold      = w_out_valid & stg.stall;
        w_accept    = stg.in_valid & ~w_hold & ~stg.flush;
    end

    // The same two muxes serve capture (decode operands) and hold (re-snoop the stored operands).
    always_comb begin
        w_a_src  = w_hold ? r_rs_addr : stg.rs_addr;
        w_b_src  = w_hold ? r_rt_addr : stg.rt_addr;
        w_a_base = w_hold ? r_a : stg.rs_data;
        w_b_base = w_hold ? r_b : stg.rt_data;
    end

    alu_operand_stage_fwd_mux u_fwd_a (
        .i_src_addr (w_a_src),
        .i_rf_data  (w_a_base),
        .i_wb_first (w_hold),
        .i_mem_we   (stg.mem_fwd_we),
        .i_mem_addr (stg.mem_fwd_addr),
        .i_mem_data (stg.mem_fwd_data),
        .i_wb_we    (stg.wb_fwd_we),
        .i_wb_addr  (stg.wb_fwd_addr),
        .i_wb_data  (stg.wb_fwd_data),
        .o_data     (w_a_sel)
    );

    alu_operand_stage_fwd_mux u_fwd_b (
        .i_src_addr (w_b_src),
        .i_rf_data  (w_b_base),
        .i_wb_first (w_hold),
        .i_mem_we   (stg.mem_fwd_we),
        .i_mem_addr (stg.mem_fwd_addr),
        .i_mem_data (stg.mem_fwd_data),
        .i_wb_we    (stg.wb_fwd_we),
        .i_wb_addr  (stg.wb_fwd_addr),
        .i_wb_data  (stg.wb_fwd_data),
        .o_data     (w_b_sel)
    );

    // Whenever the stage goes empty the ALU sees NOP with zero operands.
    always_ff @(posedge i_clk) begin
        if (i_reset || stg.flush) begin
            r_a       <= '0;
            r_b       <= '0;
            r_alucont <= ALU_NOP;
            r_dest    <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_use_imm <= 1'b0;
        end else if (w_hold) begin
            r_a <= w_a_sel;
            r_b <= r_use_imm ? r_b : w_b_sel;
        end else if (w_accept) begin
            r_a       <= w_a_sel;
            r_b       <= stg.use_imm ? stg.imm : w_b_sel;
            r_alucont <= stg.alucont_in;
            r_dest    <= stg.rd_addr;
            r_rs_addr <= stg.rs_addr;
            r_rt_addr <= stg.rt_addr;
            r_use_imm <= stg.use_imm;
        end else begin
            r_a       <= '0;
            r_b       <= '0;
            r_alucont <= ALU_NOP;
            r_dest    <= '0;
        end
    end

    assign stg.out_valid = w_out_valid;
    assign stg.in_ready  = ~stg.stall | ~w_out_valid;
    assign stg.a         = r_a;
    assign stg.b         = r_b;
    assign stg.alucont   = r_alucont;
    assign stg.dest_addr = r_dest;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected outputs queued at drive time, checked one cycle later.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

`ifdef ALU_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        ov;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  alu;
        logic [4:0]  dest;
        int          lvl;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    alu_operand_stage_if bus();

    alu_operand_stage dut (
        .i_clk   (clk),
        .i_reset (rst),
        .stg     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [31:0] im, input logic ui, input logic [5:0] alu);
        bus.in_valid   = v;
        bus.rs_addr    = rs;
        bus.rs_data    = rsd;
        bus.rt_addr    = rt;
        bus.rt_data    = rtd;
        bus.rd_addr    = rd;
        bus.imm        = im;
        bus.use_imm    = ui;
        bus.alucont_in = alu;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] ma, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
        bus.mem_fwd_we   = mwe;
        bus.mem_fwd_addr = ma;
        bus.mem_fwd_data = md;
        bus.wb_fwd_we    = wwe;
        bus.wb_fwd_addr  = wa;
        bus.wb_fwd_data  = wd;
    endtask

    // lvl 0: valid/alucont only; 1: also a/b; 2: also dest_addr.
    task automatic tick(input string name, input logic ov, input logic [31:0] ea,
                        input logic [31:0] eb, input logic [5:0] ealu, input logic [4:0] ed,
                        input int lvl);
        exp_t e;
        e.ov = ov; e.a = ea; e.b = eb; e.alu = ealu; e.dest = ed; e.lvl = lvl;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check({name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, e.ov});
        check({name, ".alucont"}, {26'd0, bus.alucont}, {26'd0, e.alu});
        if (e.lvl >= 1) begin
            check({name, ".a"}, bus.a, e.a);
            check({name, ".b"}, bus.b, e.b);
        end
        if (e.lvl >= 2) check({name, ".dest"}, {27'd0, bus.dest_addr}, {27'd0, e.dest});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_in(1'b1, 5'd3, 32'h5, 5'd4, 32'h7, 5'd9, 32'h0, 1'b0, ALU_ADD);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);

        for (int i = 0; i < 3; i++) tick("reset", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 2);
        #1;
        check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);

        rst = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, ALU_ADD);
        tick("idle", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 0);

        set_in(1'b1, 5'd3, 32'h5, 5'd4, 32'h7, 5'd9, 32'h0, 1'b0, ALU_ADD);
        tick("basic", 1'b1, 32'h5, 32'h7, ALU_ADD, 5'd9, 2);

        set_in(1'b1, 5'd3, 32'hAAAA, 5'd5, 32'h55, 5'd10, 32'h0, 1'b0, ALU_SUB);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        tick("mem_beats_wb", 1'b1, FWD ? 32'h11 : 32'hAAAA, 32'h55, ALU_SUB, 5'd10, 2);

        set_in(1'b1, 5'd3, 32'h30, 5'd5, 32'h50, 5'd11, 32'h0, 1'b0, ALU_AND);
        set_fwd(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h33);
        tick("wb_on_b", 1'b1, 32'h30, FWD ? 32'h33 : 32'h50, ALU_AND, 5'd11, 2);

        set_in(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0, 1'b0, ALU_OR);
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        tick("r0_no_fwd", 1'b1, 32'h0, 32'h0, ALU_OR, 5'd1, 2);

        set_in(1'b1, 5'd7, 32'h70, 5'd7, 32'h71, 5'd2, 32'h0, 1'b0, ALU_ADD);
        set_fwd(1'b0, 5'd7, 32'h1, 1'b0, 5'd7, 32'h2);
        tick("we_low", 1'b1, 32'h70, 32'h71, ALU_ADD, 5'd2, 2);

        set_in(1'b1, 5'd2, 32'h200, 5'd4, 32'h400, 5'd12, 32'h0, 1'b0, ALU_OR);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick("pre_hold", 1'b1, 32'h200, 32'h400, ALU_OR, 5'd12, 2);

        bus.stall = 1'b1;
        set_in(1'b1, 5'd1, 32'h1, 5'd1, 32'h1, 5'd13, 32'h0, 1'b0, ALU_SUB);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h99);
        #1;
        check("held.in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick("held1_wb_b", 1'b1, 32'h200, FWD ? 32'h99 : 32'h400, ALU_OR, 5'd12, 2);

        set_fwd(1'b1, 5'd2, 32'h55, 1'b1, 5'd2, 32'h66);
        tick("held2_wb_wins", 1'b1, FWD ? 32'h66 : 32'h200, FWD ? 32'h99 : 32'h400,
             ALU_OR, 5'd12, 2);

        bus.stall = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, ALU_ADD);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick("drain", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 0);

        set_in(1'b1, 5'd1, 32'h10, 5'd8, 32'h800, 5'd3, 32'hFFFF_FFFC, 1'b1, ALU_ADD);
        set_fwd(1'b1, 5'd8, 32'h12, 1'b0, 5'd0, 32'h0);
        tick("imm_no_fwd", 1'b1, 32'h10, 32'hFFFF_FFFC, ALU_ADD, 5'd3, 2);

        bus.stall = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, ALU_ADD);
        set_fwd(1'b1, 5'd1, 32'h99, 1'b1, 5'd8, 32'h56);
        tick("held_imm", 1'b1, FWD ? 32'h99 : 32'h10, 32'hFFFF_FFFC, ALU_ADD, 5'd3, 2);

        bus.flush = 1'b1;
        set_in(1'b1, 5'd2, 32'h2, 5'd2, 32'h2, 5'd4, 32'h0, 1'b0, ALU_SUB);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick("flush_over_stall", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 1);

        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, ALU_ADD);
        tick("flush_dropped", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 0);

        set_in(1'b1, 5'd5, 32'h5A, 5'd6, 32'h6B, 5'd7, 32'h0, 1'b0, ALU_AND);
        tick("after_flush", 1'b1, 32'h5A, 32'h6B, ALU_AND, 5'd7, 2);

        bus.flush = 1'b1;
        set_in(1'b1, 5'd9, 32'h9, 5'd9, 32'h9, 5'd9, 32'h0, 1'b0, ALU_OR);
        tick("flush_live", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 1);

        bus.flush = 1'b0;
        set_in(1'b1, 5'd9, 32'h90, 5'd10, 32'hA0, 5'd8, 32'h0, 1'b0, ALU_SUB);
        tick("reaccept", 1'b1, 32'h90, 32'hA0, ALU_SUB, 5'd8, 2);

        rst = 1'b1;
        bus.stall = 1'b1;
        tick("reset_mid_stall", 1'b0, 32'h0, 32'h0, ALU_NOP, 5'd0, 2);

        rst = 1'b0;
        set_in(1'b1, 5'd3, 32'h33, 5'd4, 32'h44, 5'd5, 32'h0, 1'b0, ALU_ADD);
        #1;
        check("empty_stall.in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick("accept_empty_stall", 1'b1, 32'h33, 32'h44, ALU_ADD, 5'd5, 2);

        set_in(1'b1, 5'd6, 32'h66, 5'd7, 32'h77, 5'd6, 32'h0, 1'b0, ALU_OR);
        tick("hold_no_accept", 1'b1, 32'h33, 32'h44, ALU_ADD, 5'd5, 2);

        bus.stall = 1'b0;
        tick("held_to_live", 1'b1, 32'h66, 32'h77, ALU_OR, 5'd6, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
